nibble_serial_addsub: RTL and testbench
=======================================

// Module: nibble_serial_addsub
// PURPOSE
//   Multi-cycle WIDTH-bit add/subtract unit for the Octa16 datapath, built on the 4-bit cla.
//   - Accepts an operand pair over a valid/ready handshake.
//   - Feeds one nibble per cycle (LSB first) into a single cla instance.
//   - Keeps the inter-nibble carry in a flip-flop.
//   - Returns sum plus C/V/Z flags over a second valid/ready handshake.
// PARAMETERS
//   WIDTH     16  operand/result width; must be a multiple of 4 (elaboration error otherwise)
//   NIBBLES   derived localparam = WIDTH/4; number of RUN cycles per operation
// PORTS
//   clk        in   1      single clock; all state changes on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand pair a/b/op/cin is valid
//   in_ready   out  1      unit can accept an operation
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   op         in   1      0 = ADD (a+b+cin), 1 = SUB (a-b); only honoured under SUB_EN
//   cin        in   1      carry-in for ADD; ignored for SUB
//   out_valid  out  1      result and flags are valid
//   out_ready  in   1      consumer takes the result
//   sum        out  WIDTH  result
//   cout       out  1      carry out of the MSB; for SUB, 1 = no borrow
//   ovf        out  1      two's-complement overflow
//   zero       out  1      sum == 0
// BEHAVIOUR
//   - Reset: state=IDLE, out_valid=0, sum=0, cout=0, ovf=0, zero=0, nibble index k=0, carry reg=0.
//     in_ready=0 while rst is high.
//   - FSM states: IDLE, RUN, DONE.
//   - IDLE:
//     - in_ready=1.
//     - On in_valid&in_ready, latch a, b' and carry; clear k; go to RUN.
//     - ADD: b' = b, carry = cin. SUB: b' = ~b, carry = 1.
//   - RUN:
//     - in_ready=0.
//     - cla inputs: A=a[4k+:4], B=b'[4k+:4], Cin=carry reg.
//     - Write sum[4k+:4] from the cla S output; carry reg <= cla Cout; k <= k+1.
//     - At k==NIBBLES-1: go to DONE and register cout, ovf, zero from the final values.
//   - DONE:
//     - out_valid=1; sum and flags held stable.
//     - On out_ready, go to IDLE with out_valid=0 the next cycle.
//     - With out_ready low, hold indefinitely (backpressure).
//   - Latency and throughput:
//     - Accept in cycle T; out_valid first high in cycle T+NIBBLES+1.
//     - in_ready is high only in IDLE, so at most one operation per NIBBLES+2 cycles.
//   - Flags:
//     - cout = final carry reg.
//     - ovf = cin_msb ^ cout, with cin_msb = a[W-1] ^ b'[W-1] ^ sum[W-1].
//     - zero = ~|sum.
//   - Boundaries:
//     - k wraps to 0 only on a new accept, never inside RUN.
//     - in_valid while busy is ignored; the producer must hold its data.
//     - rst in any state aborts the operation: partial sum is discarded, no out_valid pulse.
//     - out_ready while out_valid=0 has no effect.
// CONFIGURATION
//   - SUB_EN defined: op=1 performs a - b as above.
//   - SUB_EN undefined: op is ignored and always treated as ADD (b'=b, carry=cin); the port
//     remains for interface stability.
// STRUCTURE
//   - Package octa_alu_pkg:
//     - NIBBLE_W=4.
//     - OP_ADD=1'b0, OP_SUB=1'b1.
//     - typedef enum {IDLE, RUN, DONE} addsub_state_t.
//   - One sub-module: a single instance of cla (4-bit carry-lookahead adder); no other hierarchy.
// TESTING
//   - ADD a=0x1234 b=0x4321 cin=0 -> sum=0x5555, cout=0, ovf=0, zero=0; out_valid at T+5.
//   - ADD a=0xFFFF b=0x0001 cin=0 -> sum=0x0000, cout=1, ovf=0, zero=1.
//   - ADD a=0x7FFF b=0x0000 cin=1 -> sum=0x8000, cout=0, ovf=1, zero=0.
//   - SUB_EN, SUB a=0x0005 b=0x0007 -> sum=0xFFFE, cout=0 (borrow), ovf=0.
//     Without SUB_EN, the same stimulus gives sum=0x000C.
//   - out_ready held low 3 cycles in DONE -> sum/flags stable, in_ready=0, second in_valid not
//     accepted until after the out handshake.
//   - rst asserted in 2nd RUN cycle -> next cycle IDLE, out_valid=0, sum=0; no result emitted
//     for the aborted op.

Source files
------------

// File: rtl/octa_alu_pkg.sv
// Shared types and constants for the Octa16 ALU datapath blocks.
package octa_alu_pkg;

   localparam int NIBBLE_W = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } addsub_state_t;

endpackage

// File: rtl/nibble_serial_addsub_cla.sv
// 4-bit carry-lookahead adder: the single arithmetic core reused each cycle
// by nibble_serial_addsub.
module cla (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   always_comb begin
      g = a & b;
      p = a ^ b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
      s    = p ^ c[3:0];
      cout = c[4];
   end

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle WIDTH-bit add/subtract, one nibble per cycle through a single cla.
// Define SUB_EN to honour op=1 (a - b); otherwise every operation is an ADD.
module nibble_serial_addsub #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   import octa_alu_pkg::*;

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int KW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

   if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
      $error("nibble_serial_addsub: WIDTH must be a positive multiple of 4");
   end

   addsub_state_t    state_q, state_d;
   logic [KW-1:0]    k_q;
   logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
   logic [WIDTH-1:0] b_prep;
   logic             carry_q, carry_prep;
   logic             cout_q, ovf_q, zero_q;
   logic             is_sub, accept, msb_cin;
   logic [3:0]       cla_s;
   logic             cla_cout;
   int               nib_lsb;

`ifdef SUB_EN
   assign is_sub = (op == OP_SUB);
`else
   logic unused_op;
   assign unused_op = op;
   assign is_sub    = 1'b0;
`endif

   // Subtraction is a + ~b + 1, so only the B operand and seed carry differ.
   assign b_prep     = is_sub ? ~b : b;
   assign carry_prep = is_sub ? 1'b1 : cin;

   assign in_ready  = (state_q == IDLE) && !rst;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

   assign nib_lsb = int'(k_q) * NIBBLE_W;

   cla u_cla (
      .a    (a_q[nib_lsb +: NIBBLE_W]),
      .b    (b_q[nib_lsb +: NIBBLE_W]),
      .cin  (carry_q),
      .s    (cla_s),
      .cout (cla_cout)
   );

   // Full sum as it will look after this cycle's nibble, so flags can be
   // registered in the same edge that writes the last nibble.
   always_comb begin
      sum_d = sum_q;
      sum_d[nib_lsb +: NIBBLE_W] = cla_s;
      msb_cin = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_d[WIDTH-1];
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept)         state_d = RUN;
         RUN:     if (k_q == K_LAST)  state_d = DONE;
         DONE:    if (out_ready)      state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && accept) begin
            a_q     <= a;
            b_q     <= b_prep;
            carry_q <= carry_prep;
            k_q     <= '0;
         end
         if (state_q == RUN) begin
            sum_q   <= sum_d;
            carry_q <= cla_cout;
            if (k_q == K_LAST) begin
               cout_q <= cla_cout;
               ovf_q  <= msb_cin ^ cla_cout;
               zero_q <= ~|sum_d;
            end else begin
               k_q <= k_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Scoreboard bench for nibble_serial_addsub (WIDTH=16); honours SUB_EN the same way as the RTL build.
module tb_nibble_serial_addsub;

   localparam int W       = 16;
   localparam int NIBBLES = W / 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a, b;
   logic         op, cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout, ovf, zero;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         zero;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   nibble_serial_addsub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Reference: plain integer arithmetic on the whole word.
   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mop, input logic mcin);
      exp_t         e;
      logic [W:0]   full;
      logic [W-1:0] bb;
      logic         c0;
`ifdef SUB_EN
      bb = mop ? ~mb : mb;
      c0 = mop ? 1'b1 : mcin;
`else
      bb = mb;
      c0 = mcin;
`endif
      full   = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, c0};
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.ovf  = (ma[W-1] == bb[W-1]) && (e.sum[W-1] != ma[W-1]);
      e.zero = (e.sum == '0);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vop, input logic vcin);
      int n = 0;
      a = va; b = vb; op = vop; cin = vcin;
      in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      check("in_ready_wait", {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      exp_q.push_back(model(va, vb, vop, vcin));
   endtask

   // Called right after the accept edge; counts edges until out_valid.
   task automatic recv(input int hold);
      int   n = 0;
      exp_t e;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      check("out_valid_seen", {31'b0, out_valid}, 32'd1);
      check("latency", n, NIBBLES);
      check("queue_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         for (int i = 0; i < hold; i++) begin
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
            check("hold_sum", {16'b0, sum}, {16'b0, e.sum});
            check("hold_cout", {31'b0, cout}, {31'b0, e.cout});
            tick();
         end
         check("sum", {16'b0, sum}, {16'b0, e.sum});
         check("cout", {31'b0, cout}, {31'b0, e.cout});
         check("ovf", {31'b0, ovf}, {31'b0, e.ovf});
         check("zero", {31'b0, zero}, {31'b0, e.zero});
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("out_valid_drop", {31'b0, out_valid}, 32'd0);
      check("in_ready_after", {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; op = 1'b0; cin = 1'b0;
      tick(); tick();
      check("rst_in_ready", {31'b0, in_ready}, 32'd0);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_sum", {16'b0, sum}, 32'd0);
      check("rst_flags", {29'b0, cout, ovf, zero}, 32'd0);
      rst = 1'b0;
      #1;
      check("idle_in_ready", {31'b0, in_ready}, 32'd1);

      // out_ready while nothing is valid must not disturb anything
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("stray_out_ready", {31'b0, out_valid}, 32'd0);

      send(16'h1234, 16'h4321, 1'b0, 1'b0); recv(0);   // 0x5555
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0); recv(0);   // 0x0000, cout, zero
      send(16'h7FFF, 16'h0000, 1'b0, 1'b1); recv(0);   // 0x8000, ovf
      send(16'h0005, 16'h0007, 1'b1, 1'b0); recv(0);   // SUB: 0xFFFE / ADD: 0x000C
      send(16'h8000, 16'h0001, 1'b1, 1'b1); recv(0);   // SUB overflow / ADD with cin
      send(16'h8000, 16'h8000, 1'b0, 1'b0); recv(0);   // cout, ovf, zero together
      send(16'h0F0F, 16'h00F1, 1'b0, 1'b1); recv(0);   // carry ripples across nibbles

      // Backpressure: second operation offered while the first sits in DONE
      send(16'hA5A5, 16'h1111, 1'b0, 1'b0);
      a = 16'h0100; b = 16'h0200; op = 1'b0; cin = 1'b1;
      in_valid = 1'b1;
      recv(3);
      tick();
      in_valid = 1'b0;
      exp_q.push_back(model(16'h0100, 16'h0200, 1'b0, 1'b1));
      recv(0);

      // Reset during the second RUN cycle aborts the operation
      send(16'h1111, 16'h2222, 1'b0, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      check("abort_out_valid", {31'b0, out_valid}, 32'd0);
      check("abort_sum", {16'b0, sum}, 32'd0);
      check("abort_in_ready", {31'b0, in_ready}, 32'd0);
      void'(exp_q.pop_back());
      rst = 1'b0;
      #1;
      check("abort_idle", {31'b0, in_ready}, 32'd1);
      for (int i = 0; i < NIBBLES + 3; i++) begin
         check("abort_no_result", {31'b0, out_valid}, 32'd0);
         tick();
      end

      send(16'h0001, 16'h0001, 1'b0, 1'b0); recv(0);
      check("queue_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
